// File: rtl/cmp_mon_pkg.sv
// cmp_mon_pkg: shared state encoding and constants for the CMP end-of-program monitor.
package cmp_mon_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_TIMEOUT} mon_state_t;
    localparam logic [31:0] HALT_INST_DEF = 32'h00000000;
    localparam int DRAIN_W = 8;
endpackage

// File: rtl/cmp_halt_detector.sv
// cmp_halt_detector: per-node sticky flag set once the halt instruction has been
// seen on HALT_HOLD consecutive edges.
import cmp_mon_pkg::*;
module cmp_halt_detector #(
    parameter int INST_W = 32,
    parameter logic [INST_W-1:0] HALT_INST = INST_W'(HALT_INST_DEF),
    parameter int HALT_HOLD = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [INST_W-1:0] inst,
    output logic              halted
);
    logic [3:0] hold_q, hold_d;
    logic       halted_q, halted_d;
    logic       match;
    always_comb begin
        match    = inst == HALT_INST;
        hold_d   = match ? ((&hold_q) ? hold_q : hold_q + 4'd1) : 4'd0;
        halted_d = halted_q | (match && hold_q == 4'(HALT_HOLD - 1));
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            halted_q <= halted_d;
        end
    end
    assign halted = halted_q;
endmodule

// File: rtl/cmp_run_monitor.sv
// cmp_run_monitor: watches every node's fetch stream for the halt instruction,
// then times a drain window and reports done, or timeout from the run watchdog.
import cmp_mon_pkg::*;
module cmp_run_monitor #(
    parameter int NUM_NODES = 4,
    parameter int INST_W = 32,
    parameter logic [INST_W-1:0] HALT_INST = INST_W'(HALT_INST_DEF),
    parameter int HALT_HOLD = 1,
    parameter int DRAIN_CYCLES = 5,
    parameter int CYC_W = 32,
    parameter int TIMEOUT = 12500
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_NODES-1:0]        node_mask,
    input  logic [NUM_NODES*INST_W-1:0] inst_in,
    output logic [CYC_W-1:0]            cycle_count,
    output logic [NUM_NODES-1:0]        node_halted,
    output logic                        all_halted,
    output logic [CYC_W-1:0]            run_cycles,
    output logic                        drain_active,
    output logic                        done,
    output logic                        timeout
);
    localparam logic [CYC_W-1:0]   TO_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DR_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    mon_state_t           st_q, st_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d, run_q, run_d;
    logic [DRAIN_W-1:0]   dcnt_q, dcnt_d;
    logic [NUM_NODES-1:0] mask_q, mask_d, mask_eff, halted;
    logic                 to_hit;
    // Masked nodes see the complement of the halt word so they can never set their flag.
    for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
        cmp_halt_detector #(
            .INST_W(INST_W),
            .HALT_INST(HALT_INST),
            .HALT_HOLD(HALT_HOLD)
        ) u_det (
            .CLK(CLK),
            .RESET(RESET),
            .inst(mask_eff[i] ? inst_in[(NUM_NODES-1-i)*INST_W +: INST_W] : ~HALT_INST),
            .halted(halted[i])
        );
    end
    always_comb begin
        mask_eff   = (st_q == ST_RUN) ? node_mask : mask_q;
        mask_d     = mask_eff;
        all_halted = ~RESET & (&(halted | ~mask_eff));
        to_hit     = (TIMEOUT != 0) && cyc_q == TO_LAST;
        cyc_d      = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
        dcnt_d     = dcnt_q + DRAIN_W'(1);
        run_d      = run_q;
        st_d       = st_q;
        if (st_q == ST_RUN) begin
            dcnt_d = '0;
            if (all_halted) begin
                run_d = cyc_q;
                st_d  = (DRAIN_CYCLES == 0) ? ST_DONE : to_hit ? ST_TIMEOUT : ST_DRAIN;
            end else if (to_hit) begin
                st_d = ST_TIMEOUT;
            end
        end else if (st_q == ST_DRAIN) begin
            st_d = (dcnt_q == DR_LAST) ? ST_DONE : to_hit ? ST_TIMEOUT : ST_DRAIN;
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_q   <= ST_RUN;
            cyc_q  <= '0;
            run_q  <= '0;
            dcnt_q <= '0;
            mask_q <= '0;
        end else begin
            st_q   <= st_d;
            cyc_q  <= cyc_d;
            run_q  <= run_d;
            dcnt_q <= dcnt_d;
            mask_q <= mask_d;
        end
    end
    assign cycle_count  = cyc_q;
    assign node_halted  = halted;
    assign run_cycles   = run_q;
    assign drain_active = st_q == ST_DRAIN;
    assign done         = st_q == ST_DONE;
    assign timeout      = st_q == ST_TIMEOUT;
endmodule

// File: tb/tb_cmp_run_monitor.sv
// tb_cmp_run_monitor: directed scenarios for the run monitor; dut1 uses defaults,
// dut2 uses HALT_HOLD=3 and TIMEOUT=100.
module tb_cmp_run_monitor;
    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [3:0]   m1 = 4'hF, m2 = 4'hF;
    logic [127:0] i1 = '1, i2 = '1;
    logic [31:0]  c1, rc1, c2, rc2;
    logic [3:0]   nh1, nh2;
    logic         ah1, da1, dn1, to1, ah2, da2, dn2, to2;
    int           checks = 0;
    int           errors = 0;

    always #5 CLK = ~CLK;

    cmp_run_monitor dut1 (
        .CLK(CLK), .RESET(RESET), .node_mask(m1), .inst_in(i1),
        .cycle_count(c1), .node_halted(nh1), .all_halted(ah1), .run_cycles(rc1),
        .drain_active(da1), .done(dn1), .timeout(to1)
    );

    cmp_run_monitor #(.HALT_HOLD(3), .TIMEOUT(100)) dut2 (
        .CLK(CLK), .RESET(RESET), .node_mask(m2), .inst_in(i2),
        .cycle_count(c2), .node_halted(nh2), .all_halted(ah2), .run_cycles(rc2),
        .drain_active(da2), .done(dn2), .timeout(to2)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] pack(input logic [3:0] nop);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[(3-i)*32 +: 32] = nop[i] ? 32'h0 : 32'h00000013 + i;
        return v;
    endfunction

    task automatic do_reset;
        i1 = pack(4'h0);
        i2 = pack(4'h0);
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        m1 = 4'h0;
        m2 = 4'h0;
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i1 = {$urandom, $urandom, $urandom, $urandom};
            i2 = 128'h0;
            tick;
        end
        checks++;
        if ({c1, nh1, ah1, rc1, da1, dn1, to1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got cc=%0d nh=%b ah=%b rc=%0d d/dn/to=%b%b%b, want all 0", c1, nh1, ah1, rc1, da1, dn1, to1);
        end
        checks++;
        if ({c2, nh2, ah2, rc2, da2, dn2, to2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: got cc=%0d nh=%b ah=%b rc=%0d d/dn/to=%b%b%b, want all 0", c2, nh2, ah2, rc2, da2, dn2, to2);
        end
    endtask

    task automatic run_s1(input int stop_n, input bit final_chk);
        int t[4] = '{10, 20, 15, 30};
        logic [3:0] b;
        for (int n = 1; n <= stop_n; n++) begin
            for (int i = 0; i < 4; i++) b[i] = n >= t[i];
            i1 = pack(b);
            tick;
            checks++;
            if (c1 !== 32'(n)) begin
                errors++;
                $display("FAIL s1_cycle: got %0d want %0d", c1, n);
            end
            checks++;
            if (nh1 !== b) begin
                errors++;
                $display("FAIL s1_halted n=%0d: got %b want %b", n, nh1, b);
            end
            checks++;
            if ({da1, dn1, to1} !== {n >= 31 && n <= 35, n >= 36, 1'b0}) begin
                errors++;
                $display("FAIL s1_state n=%0d: got drain/done/to=%b%b%b want %b%b0", n, da1, dn1, to1, n >= 31 && n <= 35, n >= 36);
            end
        end
        if (final_chk) begin
            checks++;
            if (rc1 !== 32'd30 || dn1 !== 1'b1) begin
                errors++;
                $display("FAIL s1_final: got run_cycles=%0d done=%b want 30 1", rc1, dn1);
            end
        end
    endtask

    task automatic test_staggered;
        m1 = 4'hF;
        do_reset;
        run_s1(40, 1'b1);
    endtask

    task automatic test_sticky;
        logic [3:0] b, e;
        m1 = 4'hF;
        do_reset;
        for (int n = 1; n <= 28; n++) begin
            b = {n >= 25, n >= 18, n == 8 || n >= 20, n >= 12};
            e = {n >= 25, n >= 18, n >= 8, n >= 12};
            i1 = pack(b);
            tick;
            checks++;
            if (nh1 !== e || da1 !== (n >= 26)) begin
                errors++;
                $display("FAIL sticky n=%0d: got nh=%b drain=%b want %b %b", n, nh1, da1, e, n >= 26);
            end
        end
        checks++;
        if (rc1 !== 32'd25) begin
            errors++;
            $display("FAIL sticky_run_cycles: got %0d want 25", rc1);
        end
    endtask

    task automatic test_mask_end;
        m1 = 4'hF;
        do_reset;
        for (int n = 1; n <= 12; n++) begin
            if (n == 10) m1 = 4'h7;
            i1 = pack(4'b0111);
            tick;
            checks++;
            if (nh1 !== 4'b0111 || da1 !== (n >= 10)) begin
                errors++;
                $display("FAIL mask_end n=%0d: got nh=%b drain=%b want 0111 %b", n, nh1, da1, n >= 10);
            end
        end
        checks++;
        if (rc1 !== 32'd9) begin
            errors++;
            $display("FAIL mask_end_run_cycles: got %0d want 9", rc1);
        end
    endtask

    task automatic test_empty_mask;
        m1 = 4'h0;
        do_reset;
        checks++;
        if (ah1 !== 1'b1 || nh1 !== 4'h0) begin
            errors++;
            $display("FAIL empty_all_halted: got ah=%b nh=%b want 1 0000", ah1, nh1);
        end
        for (int n = 1; n <= 7; n++) begin
            tick;
            checks++;
            if ({da1, dn1} !== {n <= 5, n >= 6}) begin
                errors++;
                $display("FAIL empty_state n=%0d: got drain/done=%b%b want %b%b", n, da1, dn1, n <= 5, n >= 6);
            end
        end
        checks++;
        if (rc1 !== 32'd0) begin
            errors++;
            $display("FAIL empty_run_cycles: got %0d want 0", rc1);
        end
    endtask

    task automatic test_hold3;
        logic [3:0] e;
        m2 = 4'hF;
        do_reset;
        for (int n = 1; n <= 12; n++) begin
            i2 = pack({1'b0, n == 5 || n >= 7, 2'b00});
            e = {1'b0, n >= 9, 2'b00};
            tick;
            checks++;
            if (nh2 !== e) begin
                errors++;
                $display("FAIL hold3 n=%0d: got %b want %b", n, nh2, e);
            end
        end
    endtask

    task automatic test_timeout;
        logic [3:0] e;
        m2 = 4'hF;
        do_reset;
        for (int n = 1; n <= 105; n++) begin
            i2 = pack(4'b0111);
            e = (n >= 3) ? 4'b0111 : 4'b0000;
            tick;
            checks++;
            if (c2 !== 32'(n) || nh2 !== e || {da2, dn2, to2} !== {2'b00, n >= 100}) begin
                errors++;
                $display("FAIL timeout n=%0d: got cc=%0d nh=%b d/dn/to=%b%b%b want %0d %b 00%b", n, c2, nh2, da2, dn2, to2, n, e, n >= 100);
            end
        end
        checks++;
        if (rc2 !== 32'd0) begin
            errors++;
            $display("FAIL timeout_run_cycles: got %0d want 0", rc2);
        end
    endtask

    task automatic test_reset_in_drain;
        m1 = 4'hF;
        do_reset;
        run_s1(33, 1'b0);
        RESET = 1'b1;
        tick;
        checks++;
        if ({c1, nh1, ah1, rc1, da1, dn1, to1} !== '0) begin
            errors++;
            $display("FAIL drain_reset: got cc=%0d nh=%b ah=%b rc=%0d d/dn/to=%b%b%b want all 0", c1, nh1, ah1, rc1, da1, dn1, to1);
        end
        i1 = pack(4'h0);
        RESET = 1'b0;
        #1;
        run_s1(40, 1'b1);
    endtask

    initial begin
        test_reset;
        test_staggered;
        test_sticky;
        test_mask_end;
        test_empty_mask;
        test_hold3;
        test_timeout;
        test_reset_in_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmp_run_monitor.md
Name: cmp_run_monitor

Overview:
Synthesizable end-of-program monitor for the N-node Cardinal CMP.
- Watches every node's fetched instruction and detects when each node has settled on the halt instruction (NOP, 32'h00000000).
- Counts run cycles, then times a pipeline-drain window, and reports done or timeout.
- Sits beside cardinal_cmp in simulation, synthesized, and FPGA builds, so it replaces the bench-only wait/#timeout logic and scales to any node count.

Parameters:
- NUM_NODES, 4: number of CMP nodes monitored.
- INST_W, 32: instruction width per node.
- HALT_INST, 32'h00000000: instruction value that marks program end.
- HALT_HOLD, 1: consecutive matching cycles required before a node is declared halted (1..15).
- DRAIN_CYCLES, 5: cycles between all-halted and done (0..255).
- CYC_W, 32: cycle counter width.
- TIMEOUT, 12500: cycle limit for the run; 0 disables the watchdog.

Ports:
- CLK, input, 1: system clock.
- RESET, input, 1: synchronous, active-high reset.
- node_mask, input, NUM_NODES: 1 means the node participates; 0 means the node is treated as halted.
- inst_in, input, NUM_NODES*INST_W: concatenated fetched instructions, node0 in the most-significant slice.
- cycle_count, output, CYC_W: cycles since reset deassertion.
- node_halted, output, NUM_NODES: per-node sticky halt flags.
- all_halted, output, 1: every node is halted or masked.
- run_cycles, output, CYC_W: cycle_count latched when the FSM leaves RUN.
- drain_active, output, 1: FSM is in DRAIN.
- done, output, 1: FSM is in DONE (level).
- timeout, output, 1: FSM is in TIMEOUT (level).

Behaviour:
- Reset state: all outputs 0; FSM in RUN; hold counters 0; node_halted 0.
- Outputs stay 0 while RESET is high, whatever node_mask or inst_in do.
- Reset taken mid-operation, in any state, returns to the reset state on the next edge.

cycle_count:
- Increments by 1 on every edge with RESET low, so it reads 1 after the first post-reset edge.
- Saturates at all-ones.
- Keeps counting in DONE and TIMEOUT.

Per-node halt detection:
- hold_cnt increments on each edge where inst_in slice == HALT_INST; it resets to 0 on a mismatch.
- node_halted[i] sets on the edge where the HALT_HOLD-th consecutive match is sampled. With HALT_HOLD=1, that is the same edge as the first match.
- node_halted[i] is sticky until RESET; a later non-NOP fetch does not clear it.
- Masked nodes never set node_halted.

all_halted:
- Combinational AND over (node_halted[i] | ~node_mask[i]).
- An all-zero mask gives all_halted=1 immediately after reset.

FSM states and transitions:
- RUN -> DRAIN on the edge where all_halted=1. run_cycles <= cycle_count at that edge (pre-increment value).
- DRAIN: an 8-bit drain counter loads 0 on entry and increments each edge. DRAIN -> DONE on the edge where the counter equals DRAIN_CYCLES-1.
- DRAIN_CYCLES=0: RUN goes straight to DONE on the all_halted edge.
- RUN or DRAIN -> TIMEOUT on the edge where TIMEOUT!=0 and cycle_count == TIMEOUT-1, unless a transition to DONE occurs on that same edge.
- Simultaneous events: DONE takes priority over TIMEOUT. RUN->DRAIN on the timeout edge goes to TIMEOUT instead, and run_cycles still latches.
- DONE and TIMEOUT are terminal until RESET.

Other rules:
- node_halted keeps updating in DRAIN, DONE, and TIMEOUT; this has no effect on the state.
- node_mask changes are honoured only in RUN. A newly masked node can therefore end the run.

Decomposition:
Package cmp_mon_pkg holds:
- the state encoding RUN/DRAIN/DONE/TIMEOUT (2 bits);
- the HALT_INST default;
- the drain counter width constant (8).

Sub-module cmp_halt_detector (one per node, generated NUM_NODES times) holds hold_cnt and the sticky halted flag. Parameters are INST_W, HALT_INST, HALT_HOLD. Ports are CLK, RESET, inst, halted.

Test Plan:
1. NUM_NODES=4, mask=4'hF. Nodes 0-3 fetch NOP at cycles 10, 20, 15, 30 (cycle_count values) and hold it. Required: node_halted bits set on those edges; run_cycles=30; drain_active for 5 cycles; done=1 at cycle_count 36.
2. Node 1 fetches NOP at cycle 8, then non-NOP at 9, and all nodes reach NOP by cycle 25. Required: node_halted[1] stays 1 from cycle 8; run_cycles=25.
3. HALT_HOLD=3. Node 2 shows a NOP, non-NOP, NOP, NOP, NOP pattern starting at cycle 5. Required: node_halted[2] sets only at cycle 9.
4. TIMEOUT=100 and node 3 never fetches NOP. Required: timeout=1 after the edge with cycle_count=99; done stays 0; run_cycles=0.
5. mask=4'h0. Required: DRAIN entered on the first edge (run_cycles=0); done=1 after 5 further edges.
6. RESET asserted for 1 cycle while in DRAIN. Required: all outputs 0 on the next edge; FSM in RUN; a full rerun of scenario 1 gives identical values.
